// File: rtl/noc_flit_reader.sv
// noc_flit_reader: read-side controller for a router input FIFO.
// Pops flits from a 1-cycle-latency FIFO, checks HEAD/BODY/TAIL/SINGLE
// framing, and presents kept flits downstream through a small circular
// prefetch buffer using a valid/ready handshake.
// Optional feature: define NOC_FLIT_READER_STATS_EN to add the saturating
// stat_flits / stat_pkts counters.

module noc_flit_reader #(
   parameter int FLIT_W    = 32,
   parameter int DEST_W    = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [FLIT_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FLIT_W-1:0] out_flit,
   output logic              out_head,
   output logic              out_tail,
   output logic [DEST_W-1:0] out_dest,
   output logic              err_orphan,
   output logic              err_nested
`ifdef NOC_FLIT_READER_STATS_EN
   ,
   output logic [15:0]       stat_flits,
   output logic [15:0]       stat_pkts
`endif
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   localparam logic [1:0] TYPE_BODY   = 2'b00;
   localparam logic [1:0] TYPE_HEAD   = 2'b01;
   localparam logic [1:0] TYPE_TAIL   = 2'b10;
   localparam logic [1:0] TYPE_SINGLE = 2'b11;

   typedef enum logic {
      ST_IDLE,
      ST_PKT
   } state_t;

   state_t            state_q, state_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              pend_q, pend_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FLIT_W-1:0] mem_q [BUF_DEPTH];
   logic [FLIT_W-1:0] mem_d [BUF_DEPTH];
   logic              err_orphan_q, err_orphan_d;
   logic              err_nested_q, err_nested_d;

   logic [1:0]        flit_type;
   logic              keep;
   logic              pop;
   logic [OCC_W:0]    credit_used;
   logic [FLIT_W-1:0] head_flit;

   // Read credit: a pop is only requested when the buffer has room for every
   // flit already stored plus the one still in flight from last cycle.
   always_comb begin
      credit_used = {1'b0, occ_q} + {{OCC_W{1'b0}}, pend_q};
      fifo_rd_en  = !fifo_empty && (credit_used < (OCC_W+1)'(BUF_DEPTH));
   end

   // Framing FSM: classifies the flit arriving this cycle and decides keep/drop.
   always_comb begin
      state_d      = state_q;
      keep         = 1'b0;
      err_orphan_d = 1'b0;
      err_nested_d = 1'b0;
      flit_type    = fifo_data[FLIT_W-1 -: 2];
      if (pend_q) begin
         case (state_q)
            ST_IDLE: begin
               case (flit_type)
                  TYPE_HEAD: begin
                     keep    = 1'b1;
                     state_d = ST_PKT;
                  end
                  TYPE_SINGLE: keep = 1'b1;
                  TYPE_BODY:   err_orphan_d = 1'b1;
                  TYPE_TAIL:   err_orphan_d = 1'b1;
               endcase
            end
            ST_PKT: begin
               keep = 1'b1;
               case (flit_type)
                  TYPE_BODY:   state_d = ST_PKT;
                  TYPE_TAIL:   state_d = ST_IDLE;
                  TYPE_HEAD:   err_nested_d = 1'b1;
                  TYPE_SINGLE: begin
                     err_nested_d = 1'b1;
                     state_d      = ST_IDLE;
                  end
               endcase
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Buffer bookkeeping: write kept flits, pop on handshake, track occupancy.
   always_comb begin
      pop      = out_valid && out_ready;
      pend_d   = fifo_rd_en;
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (keep) begin
         mem_d[wr_ptr_q] = fifo_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (keep && !pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!keep && pop) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   // State register; reset discards any in-flight read and all buffered flits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         occ_q        <= '0;
         pend_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         err_orphan_q <= 1'b0;
         err_nested_q <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         pend_q       <= pend_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         err_orphan_q <= err_orphan_d;
         err_nested_q <= err_nested_d;
         mem_q        <= mem_d;
      end
   end

   // Downstream view of the buffer head entry.
   always_comb begin
      head_flit  = mem_q[rd_ptr_q];
      out_valid  = (occ_q != '0);
      out_flit   = head_flit;
      out_head   = head_flit[FLIT_W-2];
      out_tail   = head_flit[FLIT_W-1];
      out_dest   = head_flit[FLIT_W-3 -: DEST_W];
      err_orphan = err_orphan_q;
      err_nested = err_nested_q;
   end

`ifdef NOC_FLIT_READER_STATS_EN
   logic [15:0] stat_flits_q, stat_flits_d;
   logic [15:0] stat_pkts_q, stat_pkts_d;

   // Saturating counters of flits and packet ends handed downstream.
   always_comb begin
      stat_flits_d = stat_flits_q;
      stat_pkts_d  = stat_pkts_q;
      if (pop && (stat_flits_q != 16'hFFFF)) begin
         stat_flits_d = stat_flits_q + 16'd1;
      end
      if (pop && out_tail && (stat_pkts_q != 16'hFFFF)) begin
         stat_pkts_d = stat_pkts_q + 16'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_flits_q <= '0;
         stat_pkts_q  <= '0;
      end else begin
         stat_flits_q <= stat_flits_d;
         stat_pkts_q  <= stat_pkts_d;
      end
   end

   assign stat_flits = stat_flits_q;
   assign stat_pkts  = stat_pkts_q;
`endif

endmodule

// File: tb/tb_noc_flit_reader.sv
// Testbench for noc_flit_reader: FIFO model, packet-framing reference model
// and scoreboard, plus directed and randomized scenarios.

module tb_noc_flit_reader;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        fifo_rd_en;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_flit;
   logic        out_head;
   logic        out_tail;
   logic [3:0]  out_dest;
   logic        err_orphan;
   logic        err_nested;
`ifdef NOC_FLIT_READER_STATS_EN
   logic [15:0] stat_flits;
   logic [15:0] stat_pkts;
`endif

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   noc_flit_reader #(.FLIT_W(32), .DEST_W(4), .BUF_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_flit   (out_flit),
      .out_head   (out_head),
      .out_tail   (out_tail),
      .out_dest   (out_dest),
      .err_orphan (err_orphan),
      .err_nested (err_nested)
`ifdef NOC_FLIT_READER_STATS_EN
      ,
      .stat_flits (stat_flits),
      .stat_pkts  (stat_pkts)
`endif
   );

   int          errors = 0;
   int          checks = 0;

   logic [31:0] fifo_q [$];
   logic [31:0] exp_q [$];
   bit          in_pkt = 1'b0;
   int          exp_orphan = 0;
   int          exp_nested = 0;
   int          obs_orphan = 0;
   int          obs_nested = 0;
   int          pops = 0;

   logic        s_rd_en, s_out_valid, s_head, s_tail, s_orph, s_nest;
   logic [31:0] s_flit;
   logic [3:0]  s_dest;
`ifdef NOC_FLIT_READER_STATS_EN
   logic [15:0] s_stat_flits, s_stat_pkts;
`endif
   bit          prev_stall = 1'b0;
   logic [31:0] prev_flit = '0;
   bit          do_pop = 1'b0;

   // Reference framing model: decides from packet rules alone which flits reach the output.
   task automatic model_feed(input logic [31:0] f);
      logic [1:0] t;
      t = f[31:30];
      if (!in_pkt) begin
         if (t == T_HEAD) begin
            in_pkt = 1'b1;
            exp_q.push_back(f);
         end else if (t == T_SINGLE) begin
            exp_q.push_back(f);
         end else begin
            exp_orphan++;
         end
      end else begin
         exp_q.push_back(f);
         if (t == T_TAIL) begin
            in_pkt = 1'b0;
         end else if (t == T_HEAD) begin
            exp_nested++;
         end else if (t == T_SINGLE) begin
            exp_nested++;
            in_pkt = 1'b0;
         end
      end
   endtask

   // One clock cycle: sample at negedge, score handshakes, then serve the FIFO after posedge.
   task automatic tick();
      logic [31:0] e;
      logic        e_head, e_tail;
      @(negedge clk);
      s_rd_en     = fifo_rd_en;
      s_out_valid = out_valid;
      s_flit      = out_flit;
      s_head      = out_head;
      s_tail      = out_tail;
      s_dest      = out_dest;
      s_orph      = err_orphan;
      s_nest      = err_nested;
`ifdef NOC_FLIT_READER_STATS_EN
      s_stat_flits = stat_flits;
      s_stat_pkts  = stat_pkts;
`endif
      do_pop = 1'b0;
      if (rst_n) begin
         if (prev_stall) begin
            checks++;
            if (s_out_valid !== 1'b1 || s_flit !== prev_flit) begin
               errors++;
               $display("[TB] FAIL hold: valid=%b flit=%h expected valid=1 flit=%h", s_out_valid, s_flit, prev_flit);
            end
         end
         if (s_out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL extra_flit: got %h expected no flit", s_flit);
            end else begin
               e      = exp_q.pop_front();
               e_head = (e[31:30] == T_HEAD) || (e[31:30] == T_SINGLE);
               e_tail = (e[31:30] == T_TAIL) || (e[31:30] == T_SINGLE);
               if (s_flit !== e || s_head !== e_head || s_tail !== e_tail || (e_head && s_dest !== e[29:26])) begin
                  errors++;
                  $display("[TB] FAIL out_flit: got %h h%b t%b d%h expected %h h%b t%b d%h", s_flit, s_head, s_tail, s_dest, e, e_head, e_tail, e[29:26]);
               end
            end
            pops++;
         end
         prev_stall = s_out_valid && !out_ready;
         prev_flit  = s_flit;
         if (fifo_empty) begin
            checks++;
            if (s_rd_en !== 1'b0) begin
               errors++;
               $display("[TB] FAIL rd_when_empty: got rd_en=%b expected 0", s_rd_en);
            end
         end
         obs_orphan += int'(s_orph);
         obs_nested += int'(s_nest);
         do_pop = s_rd_en && !fifo_empty;
      end else begin
         prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      if (do_pop) begin
         fifo_data = fifo_q.pop_front();
         model_feed(fifo_data);
         fifo_empty = (fifo_q.size() == 0);
      end
   endtask

   task automatic push(input logic [1:0] t, input logic [3:0] d, output logic [31:0] f);
      f = {t, d, 26'($urandom)};
      fifo_q.push_back(f);
      fifo_empty = 1'b0;
   endtask

   task automatic drain(input int budget, output bit timed_out);
      out_ready = 1'b1;
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !s_out_valid) begin
            timed_out = 1'b0;
            break;
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if (s_out_valid !== 1'b0 || s_rd_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: valid=%b rd_en=%b expected 0 0", s_out_valid, s_rd_en);
      end
      checks++;
      if (s_flit !== 32'h0 || s_head !== 1'b0 || s_tail !== 1'b0 || s_dest !== 4'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: flit=%h h%b t%b d%h expected all 0", s_flit, s_head, s_tail, s_dest);
      end
      checks++;
      if (s_orph !== 1'b0 || s_nest !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_err: orphan=%b nested=%b expected 0 0", s_orph, s_nest);
      end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_stream();
      logic [31:0] f [4];
      int          o0, n0, p0;
      bit          to;
      o0 = obs_orphan; n0 = obs_nested; p0 = pops;
      out_ready = 1'b1;
      push(T_HEAD, 4'd5, f[0]);
      push(T_BODY, 4'($urandom), f[1]);
      push(T_BODY, 4'($urandom), f[2]);
      push(T_TAIL, 4'($urandom), f[3]);
      tick();
      checks++;
      if (s_rd_en !== 1'b1 || s_out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stream_c0: rd_en=%b valid=%b expected 1 0", s_rd_en, s_out_valid);
      end
      tick();
      checks++;
      if (s_out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stream_c1: valid=%b expected 0", s_out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (s_out_valid !== 1'b1 || s_flit !== f[i] || s_head !== (i == 0) || s_tail !== (i == 3)) begin
            errors++;
            $display("[TB] FAIL stream_flit%0d: valid=%b flit=%h h%b t%b expected 1 %h h%b t%b", i, s_out_valid, s_flit, s_head, s_tail, f[i], i == 0, i == 3);
         end
         if (i == 0) begin
            checks++;
            if (s_dest !== 4'd5) begin
               errors++;
               $display("[TB] FAIL stream_dest: got %0d expected 5", s_dest);
            end
         end
      end
      tick();
      checks++;
      if (s_out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stream_end: valid=%b expected 0", s_out_valid);
      end
      drain(20, to);
      checks++;
      if (to || pops - p0 !== 4 || obs_orphan - o0 !== 0 || obs_nested - n0 !== 0) begin
         errors++;
         $display("[TB] FAIL stream_totals: timeout=%b pops=%0d orph=%0d nest=%0d expected 0 4 0 0", to, pops - p0, obs_orphan - o0, obs_nested - n0);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] f [8];
      int          reads, p0;
      bit          to;
      p0 = pops;
      reads = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push((i == 0) ? T_HEAD : ((i == 7) ? T_TAIL : T_BODY), 4'($urandom), f[i]);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         reads += int'(s_rd_en);
         if (s_out_valid) begin
            checks++;
            if (s_flit !== f[0]) begin
               errors++;
               $display("[TB] FAIL bp_hold: got %h expected %h", s_flit, f[0]);
            end
         end
      end
      checks++;
      if (reads !== 4 || s_rd_en !== 1'b0 || s_out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_reads: reads=%0d rd_en=%b valid=%b expected 4 0 1", reads, s_rd_en, s_out_valid);
      end
      drain(40, to);
      checks++;
      if (to || pops - p0 !== 8) begin
         errors++;
         $display("[TB] FAIL bp_release: timeout=%b delivered=%0d expected 0 8", to, pops - p0);
      end
   endtask

   task automatic test_orphan();
      logic [31:0] f [3];
      bit          eo [6];
      bit          ev [6];
      int          o0, n0, p0;
      bit          to;
      eo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      o0 = obs_orphan; n0 = obs_nested; p0 = pops;
      out_ready = 1'b1;
      push(T_TAIL, 4'($urandom), f[0]);
      push(T_BODY, 4'($urandom), f[1]);
      push(T_SINGLE, 4'($urandom), f[2]);
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (s_orph !== eo[i] || s_out_valid !== ev[i]) begin
            errors++;
            $display("[TB] FAIL orphan_c%0d: orphan=%b valid=%b expected %b %b", i, s_orph, s_out_valid, eo[i], ev[i]);
         end
         if (ev[i]) begin
            checks++;
            if (s_flit !== f[2] || s_head !== 1'b1 || s_tail !== 1'b1) begin
               errors++;
               $display("[TB] FAIL orphan_single: flit=%h h%b t%b expected %h h1 t1", s_flit, s_head, s_tail, f[2]);
            end
         end
      end
      drain(20, to);
      checks++;
      if (to || obs_orphan - o0 !== 2 || pops - p0 !== 1 || obs_nested - n0 !== 0) begin
         errors++;
         $display("[TB] FAIL orphan_totals: timeout=%b orph=%0d pops=%0d nest=%0d expected 0 2 1 0", to, obs_orphan - o0, pops - p0, obs_nested - n0);
      end
   endtask

   task automatic test_nested();
      logic [31:0] f;
      int          o0, n0, p0;
      bit          to;
      o0 = obs_orphan; n0 = obs_nested; p0 = pops;
      out_ready = 1'b1;
      push(T_HEAD, 4'($urandom), f);
      push(T_BODY, 4'($urandom), f);
      push(T_HEAD, 4'($urandom), f);
      push(T_TAIL, 4'($urandom), f);
      push(T_BODY, 4'($urandom), f);
      drain(30, to);
      checks++;
      if (to || pops - p0 !== 4 || obs_nested - n0 !== 1 || obs_orphan - o0 !== 1) begin
         errors++;
         $display("[TB] FAIL nested_totals: timeout=%b pops=%0d nest=%0d orph=%0d expected 0 4 1 1", to, pops - p0, obs_nested - n0, obs_orphan - o0);
      end
   endtask

   task automatic test_random();
      logic [31:0] f;
      bit          to;
      for (int i = 0; i < 400; i++) begin
         if (fifo_q.size() < 12 && $urandom_range(0, 2) != 0) begin
            push(2'($urandom), 4'($urandom), f);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain(200, to);
      checks++;
      if (to || obs_orphan !== exp_orphan || obs_nested !== exp_nested) begin
         errors++;
         $display("[TB] FAIL random_errs: timeout=%b orph=%0d nest=%0d expected 0 %0d %0d", to, obs_orphan, obs_nested, exp_orphan, exp_nested);
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [31:0] f;
      int          o0, p0;
      bit          to;
      out_ready = 1'b0;
      push(T_HEAD, 4'($urandom), f);
      push(T_BODY, 4'($urandom), f);
      push(T_BODY, 4'($urandom), f);
      repeat (6) tick();
      checks++;
      if (s_out_valid !== 1'b1 || s_rd_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_pre: valid=%b rd_en=%b expected 1 0", s_out_valid, s_rd_en);
      end
      rst_n = 1'b0;
      exp_q.delete();
      in_pkt = 1'b0;
      tick();
      checks++;
      if (s_out_valid !== 1'b0 || s_rd_en !== 1'b0 || s_flit !== 32'h0) begin
         errors++;
         $display("[TB] FAIL rstmid_in: valid=%b rd_en=%b flit=%h expected 0 0 0", s_out_valid, s_rd_en, s_flit);
      end
      push(T_BODY, 4'($urandom), f);
      tick();
      checks++;
      if (s_rd_en !== 1'b1 || s_out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_rd: rd_en=%b valid=%b expected 1 0", s_rd_en, s_out_valid);
      end
      o0 = obs_orphan; p0 = pops;
      rst_n = 1'b1;
      drain(20, to);
      checks++;
      if (to || obs_orphan - o0 !== 1 || pops - p0 !== 0) begin
         errors++;
         $display("[TB] FAIL rstmid_post: timeout=%b orph=%0d pops=%0d expected 0 1 0", to, obs_orphan - o0, pops - p0);
      end
   endtask

`ifdef NOC_FLIT_READER_STATS_EN
   task automatic test_stats();
      logic [31:0] f;
      bit          to;
      rst_n = 1'b0;
      exp_q.delete();
      in_pkt = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (s_stat_flits !== 16'd0 || s_stat_pkts !== 16'd0) begin
         errors++;
         $display("[TB] FAIL stats_reset: flits=%0d pkts=%0d expected 0 0", s_stat_flits, s_stat_pkts);
      end
      push(T_SINGLE, 4'($urandom), f);
      push(T_HEAD, 4'($urandom), f);
      push(T_TAIL, 4'($urandom), f);
      push(T_HEAD, 4'($urandom), f);
      push(T_BODY, 4'($urandom), f);
      push(T_BODY, 4'($urandom), f);
      push(T_TAIL, 4'($urandom), f);
      drain(40, to);
      checks++;
      if (to || s_stat_flits !== 16'd7 || s_stat_pkts !== 16'd3) begin
         errors++;
         $display("[TB] FAIL stats_count: timeout=%b flits=%0d pkts=%0d expected 0 7 3", to, s_stat_flits, s_stat_pkts);
      end
      for (int i = 0; i < 70000; i++) begin
         push(T_SINGLE, 4'($urandom), f);
      end
      drain(70100, to);
      checks++;
      if (to || s_stat_flits !== 16'hFFFF || s_stat_pkts !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL stats_sat: timeout=%b flits=%h pkts=%h expected 0 ffff ffff", to, s_stat_flits, s_stat_pkts);
      end
   endtask
`endif

   // Scenario sequence.
   initial begin
      rst_n      = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      out_ready  = 1'b0;
      $display("[TB] starting noc_flit_reader bench");
      test_reset();
      test_stream();
      test_backpressure();
      test_orphan();
      test_nested();
      test_random();
      test_reset_mid_packet();
`ifdef NOC_FLIT_READER_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
